// File: rtl/hall_step_decoder_if.sv
// Hall decoder bus: raw hall/control inputs and decoded step/period/status outputs.
interface hall_step_decoder_if #(
    parameter int unsigned K_PERIOD_W = 16
);
    logic [2:0]            i_hall;
    logic                  i_hall_polarity_rev;
    logic                  i_clear_error;
    logic [2:0]            o_step;
    logic                  o_step_valid;
    logic                  o_step_strobe;
    logic                  o_direction;
    logic [K_PERIOD_W-1:0] o_period;
    logic                  o_period_valid;
    logic                  o_stalled;
    logic                  o_error;
    logic                  o_substep_trigger;

    modport master (
        output i_hall, i_hall_polarity_rev, i_clear_error,
        input  o_step, o_step_valid, o_step_strobe, o_direction, o_period,
               o_period_valid, o_stalled, o_error, o_substep_trigger
    );

    modport slave (
        input  i_hall, i_hall_polarity_rev, i_clear_error,
        output o_step, o_step_valid, o_step_strobe, o_direction, o_period,
               o_period_valid, o_stalled, o_error, o_substep_trigger
    );
endinterface

// File: rtl/hall_step_decoder.sv
// Hall sensor front end: sync, deglitch, decode to 6-step index, direction/period/stall/error.
// Optional substep pulse generator enabled by defining HALL_SUBSTEP_EN.
module hall_step_decoder #(
    parameter int unsigned K_FILTER_LEN = 4,
    parameter int unsigned K_PERIOD_W   = 16,
    parameter int unsigned K_NSUBSTEPS  = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    hall_step_decoder_if.slave hall_if
);

    localparam int unsigned CNT_W = (K_FILTER_LEN > 1) ? $clog2(K_FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(K_FILTER_LEN - 1);
    localparam logic [K_PERIOD_W-1:0] PER_MAX  = '1;

    if (K_FILTER_LEN < 1 || K_NSUBSTEPS < 2) begin : g_bad_param
        $error("hall_step_decoder: K_FILTER_LEN must be >= 1 and K_NSUBSTEPS >= 2");
    end

    function automatic logic [2:0] decode(input logic [2:0] code);
        case (code)
            3'b101:  decode = 3'd0;
            3'b100:  decode = 3'd1;
            3'b110:  decode = 3'd2;
            3'b010:  decode = 3'd3;
            3'b011:  decode = 3'd4;
            3'b001:  decode = 3'd5;
            default: decode = 3'd0;
        endcase
    endfunction

    logic [2:0]            sync1_q, sync2_q, prev_q;
    logic [2:0]            acc_code_q, acc_code_d;
    logic [CNT_W-1:0]      flt_cnt_q, flt_cnt_d;
    logic [K_PERIOD_W-1:0] per_cnt_q, per_cnt_d;
    logic [K_PERIOD_W-1:0] period_q, period_d;
    logic [2:0]            step_q, step_d;
    logic                  step_valid_q, step_valid_d;
    logic                  strobe_q, strobe_d;
    logic                  dir_q, dir_d;
    logic                  period_valid_q, period_valid_d;
    logic                  stalled_q, stalled_d;
    logic                  error_q, error_d;

    logic                  stable, accept, code_ok, per_sat, can_publish;
    logic [2:0]            new_step, step_diff;

    // Filter: candidate must match its previous-cycle value for K_FILTER_LEN cycles.
    always_comb begin
        stable     = (sync2_q == prev_q);
        accept     = stable && (sync2_q != acc_code_q) && (flt_cnt_q == CNT_LAST);
        flt_cnt_d  = flt_cnt_q;
        acc_code_d = acc_code_q;
        if (!stable || (sync2_q == acc_code_q)) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q != CNT_LAST) begin
            flt_cnt_d = flt_cnt_q + CNT_W'(1);
        end
        if (accept) begin
            acc_code_d = sync2_q;
        end
    end

    // Decode, direction, period publish and error tracking.
    always_comb begin
        code_ok        = (sync2_q != 3'b000) && (sync2_q != 3'b111);
        new_step       = decode(sync2_q);
        step_diff      = (new_step >= step_q) ? 3'(new_step - step_q)
                                              : 3'(4'(new_step) + 4'd6 - 4'(step_q));
        per_sat        = (per_cnt_q == PER_MAX);
        can_publish    = !stalled_q && !per_sat;

        step_d         = step_q;
        step_valid_d   = step_valid_q;
        strobe_d       = 1'b0;
        dir_d          = dir_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        stalled_d      = stalled_q;
        error_d        = error_q;

        if (hall_if.i_clear_error) begin
            error_d = 1'b0;
        end
        if (per_sat) begin
            stalled_d      = 1'b1;
            period_valid_d = 1'b0;
        end

        if (accept) begin
            if (!code_ok) begin
                error_d      = 1'b1;
                step_valid_d = 1'b0;
            end else begin
                strobe_d     = 1'b1;
                step_d       = new_step;
                step_valid_d = 1'b1;
                stalled_d    = 1'b0;
                if (step_valid_q) begin
                    if (step_diff == 3'd1 || step_diff == 3'd5) begin
                        dir_d = (step_diff == 3'd1);
                        if (can_publish) begin
                            period_d       = per_cnt_q;
                            period_valid_d = 1'b1;
                        end
                    end else begin
                        error_d        = 1'b1;
                        period_valid_d = 1'b0;
                    end
                end
            end
        end

        // Period counter restarts at 1 so a strobe-to-strobe gap of N cycles reads N.
        if (strobe_d) begin
            per_cnt_d = K_PERIOD_W'(1);
        end else if (per_sat) begin
            per_cnt_d = per_cnt_q;
        end else begin
            per_cnt_d = per_cnt_q + K_PERIOD_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q        <= 3'b000;
            sync2_q        <= 3'b000;
            prev_q         <= 3'b000;
            acc_code_q     <= 3'b000;
            flt_cnt_q      <= '0;
            per_cnt_q      <= '0;
            period_q       <= '0;
            step_q         <= 3'd0;
            step_valid_q   <= 1'b0;
            strobe_q       <= 1'b0;
            dir_q          <= 1'b1;
            period_valid_q <= 1'b0;
            stalled_q      <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            sync1_q        <= hall_if.i_hall ^ {3{hall_if.i_hall_polarity_rev}};
            sync2_q        <= sync1_q;
            prev_q         <= sync2_q;
            acc_code_q     <= acc_code_d;
            flt_cnt_q      <= flt_cnt_d;
            per_cnt_q      <= per_cnt_d;
            period_q       <= period_d;
            step_q         <= step_d;
            step_valid_q   <= step_valid_d;
            strobe_q       <= strobe_d;
            dir_q          <= dir_d;
            period_valid_q <= period_valid_d;
            stalled_q      <= stalled_d;
            error_q        <= error_d;
        end
    end

    assign hall_if.o_step         = step_q;
    assign hall_if.o_step_valid   = step_valid_q;
    assign hall_if.o_step_strobe  = strobe_q;
    assign hall_if.o_direction    = dir_q;
    assign hall_if.o_period       = period_q;
    assign hall_if.o_period_valid = period_valid_q;
    assign hall_if.o_stalled      = stalled_q;
    assign hall_if.o_error        = error_q;

`ifdef HALL_SUBSTEP_EN
    localparam int unsigned ACC_W = K_PERIOD_W + $clog2(K_NSUBSTEPS) + 1;
    localparam int unsigned SUB_W = $clog2(K_NSUBSTEPS);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(K_NSUBSTEPS - 1);

    logic [ACC_W-1:0] ph_acc_q, ph_acc_d, ph_sum;
    logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
    logic             sub_trig_q, sub_trig_d;

    // Phase accumulator: K_NSUBSTEPS per cycle against the published period.
    always_comb begin
        ph_sum     = ph_acc_q + ACC_W'(K_NSUBSTEPS);
        ph_acc_d   = ph_acc_q;
        sub_cnt_d  = sub_cnt_q;
        sub_trig_d = 1'b0;
        if (strobe_d) begin
            ph_acc_d  = '0;
            sub_cnt_d = '0;
        end else if (period_valid_q && !stalled_q && (sub_cnt_q != SUB_LAST)) begin
            if (ph_sum >= ACC_W'(period_q)) begin
                ph_acc_d   = ph_sum - ACC_W'(period_q);
                sub_trig_d = 1'b1;
                sub_cnt_d  = sub_cnt_q + SUB_W'(1);
            end else begin
                ph_acc_d   = ph_sum;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ph_acc_q   <= '0;
            sub_cnt_q  <= '0;
            sub_trig_q <= 1'b0;
        end else begin
            ph_acc_q   <= ph_acc_d;
            sub_cnt_q  <= sub_cnt_d;
            sub_trig_q <= sub_trig_d;
        end
    end

    assign hall_if.o_substep_trigger = sub_trig_q;
`else
    assign hall_if.o_substep_trigger = 1'b0;
`endif

endmodule
